// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
// Build option: PS2_TX_RETRY_EN adds the RETRY state to the state type.
package ps2_host_tx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
`ifdef PS2_TX_RETRY_EN
        , RETRY
`endif
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam int         PS2_FRAME_BITS   = 11;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Metastability synchroniser plus falling-edge detector for one PS/2 line.
// Used for both the clock and data lines; also shared with the receive path.
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw line through the sync chain; lines idle high, so reset to 1
    // to avoid a spurious falling edge when reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign fall_o  = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter using the request-to-send sequence.
// Drives open-drain enables only; pad tristates live outside this block.
// Build option: PS2_TX_RETRY_EN enables automatic resend (RETRY_MAX attempts).
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | lines released, waiting for tx_valid
//   INHIBIT   | clock held low; start bit asserted in the last cycle
//   RELEASE   | clock released, start bit on data, wait first device edge
//   DATA      | one data bit per falling edge, LSB first
//   PARITY    | drive parity on the next falling edge
//   STOP      | release data (stop bit) on the next falling edge
//   ACK       | sample device ACK on the next falling edge
//   WAIT_IDLE | wait for both lines high
//   DONE      | one-cycle tx_done
//   ERR       | one-cycle tx_err, lines released
//   RETRY     | (retry build) lines released for INHIBIT_CYCLES, then resend
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
`ifdef PS2_TX_RETRY_EN
    , parameter int RETRY_MAX    = 2
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam logic [19:0] INH_LOAD  = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] TMO_LIMIT = 20'(TIMEOUT_CYCLES);

    ps2_tx_state_t state_q, state_d;
    logic [8:0]    frame_q, frame_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [19:0]   inh_q, inh_d;
    logic [19:0]   tmo_q, tmo_d;
    logic          data_oe_q, data_oe_d;
    logic          fail_req;
    logic          wait_st;
    logic          tmo_hit;
    logic          clk_lvl, clk_fall;
    logic          data_lvl, data_fall_unused;

`ifdef PS2_TX_RETRY_EN
    localparam int RW = $clog2(RETRY_MAX + 1) + 1;
    logic [RW-1:0] retry_q, retry_d;
`endif

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_clk_i),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_data_i),
        .level_o (data_lvl),
        .fall_o  (data_fall_unused)
    );

    assign wait_st = state_q inside {RELEASE, DATA, PARITY, STOP, ACK, WAIT_IDLE};
    assign tmo_hit = (tmo_q >= TMO_LIMIT);

    // State, frame, counters and the registered data-line enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            inh_q     <= '0;
            tmo_q     <= '0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            inh_q     <= inh_d;
            tmo_q     <= tmo_d;
            data_oe_q <= data_oe_d;
        end
    end

`ifdef PS2_TX_RETRY_EN
    // Resend attempt counter, cleared when a new byte is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) retry_q <= '0;
        else     retry_q <= retry_d;
    end
`endif

    // Next-state logic: bits change on device falling edges, device samples on rising.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        inh_d     = inh_q;
        tmo_d     = tmo_q;
        data_oe_d = data_oe_q;
        fail_req  = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif

        // Watchdog on device clocking: reload on each edge, saturate otherwise.
        if (wait_st) begin
            if (clk_fall)          tmo_d = '0;
            else if (tmo_q != '1)  tmo_d = tmo_q + 20'd1;
        end

        case (state_q)
            IDLE: begin
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    frame_d   = {odd_parity(tx_data), tx_data};
                    bit_cnt_d = '0;
                    inh_d     = INH_LOAD;
                    tmo_d     = '0;
`ifdef PS2_TX_RETRY_EN
                    retry_d   = '0;
`endif
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == '0) begin
                    data_oe_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = RELEASE;
                end else begin
                    inh_d = inh_q - 20'd1;
                end
            end
            RELEASE: begin
                // The device's first falling edge asks for bit 0.
                if (clk_fall) begin
                    data_oe_d = ~frame_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    data_oe_d = ~frame_q[bit_cnt_d[2:0]];
                    if (bit_cnt_d == 4'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (clk_fall) begin
                    data_oe_d = ~frame_q[8];
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (clk_fall) begin
                    data_oe_d = 1'b0;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    if (data_lvl) fail_req = 1'b1;
                    else          state_d  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_lvl && data_lvl) state_d = DONE;
            end
            DONE, ERR: begin
                data_oe_d = 1'b0;
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
`ifdef PS2_TX_RETRY_EN
            RETRY: begin
                if (inh_q == '0) begin
                    inh_d   = INH_LOAD;
                    state_d = INHIBIT;
                end else begin
                    inh_d = inh_q - 20'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (wait_st && !clk_fall && tmo_hit) fail_req = 1'b1;

        if (fail_req) begin
            data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q < RW'(RETRY_MAX)) begin
                retry_d = retry_q + 1'b1;
                inh_d   = INH_LOAD;
                state_d = RETRY;
            end else begin
                state_d = ERR;
            end
`else
            state_d = ERR;
`endif
        end
    end

    assign ps2_clk_oe  = (state_q == INHIBIT);
    assign ps2_data_oe = data_oe_q | ((state_q == INHIBIT) && (inh_q == '0));
    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign tx_done     = (state_q == DONE);
    assign tx_err      = (state_q == ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with an open-drain PS/2 device model.
// Timing parameters are shortened so the run stays small; build with
// PS2_TX_RETRY_EN defined to exercise the resend path.
module tb_ps2_host_tx;

    localparam int INH  = 200;
    localparam int TMO  = 3000;
    localparam int HALF = 12;
`ifdef PS2_TX_RETRY_EN
    localparam int RMAX     = 2;
    localparam int ATTEMPTS = RMAX + 1;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_line, data_line;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int attempt_cnt = 0;
    logic clk_oe_prev = 1'b0;

    assign clk_line  = ~ps2_clk_oe & dev_clk;
    assign data_line = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2)
`ifdef PS2_TX_RETRY_EN
        , .RETRY_MAX    (RMAX)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .busy        (busy),
        .ps2_clk_i   (clk_line),
        .ps2_data_i  (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    // Pulse and attempt counters observed away from the active edge.
    always @(negedge clk) begin
        clk_oe_prev <= ps2_clk_oe;
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_err === 1'b1)  err_cnt  <= err_cnt + 1;
        if (ps2_clk_oe === 1'b1 && clk_oe_prev === 1'b0) attempt_cnt <= attempt_cnt + 1;
    end

    // Expected line frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic start_send(input logic [7:0] b, input bit hold, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 100);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        ok = (n < 2000);
    endtask

    // Device side of one request-to-send exchange. Returns the 11 line bits
    // sampled on rising clock edges; stop_after>0 abandons after that fall.
    task automatic device_xfer(input bit ack, input int stop_after,
                               output logic [10:0] bits, output int inh_len,
                               output bit ok);
        int n;
        ok = 1'b1;
        bits = '0;
        inh_len = 0;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            ok = 1'b0;
            return;
        end
        while (ps2_clk_oe === 1'b1 && inh_len < 20000) begin
            inh_len++;
            @(negedge clk);
        end
        bits[0] = data_line;
        repeat (10) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (e == stop_after) return;
            dev_clk = 1'b1;
            if (e <= 10) bits[e] = data_line;
            repeat (HALF / 2) @(negedge clk);
            if (e == 10 && ack) dev_data = 1'b0;
            repeat (HALF / 2) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic test_reset();
        total++;
        if (tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", tx_ready);
        end
        total++;
        if ({busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_outputs: busy/done/err/clk_oe/data_oe got %b want 00000",
                     {busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_idle_ignore();
        bit drove;
        drove = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dev_clk  = 1'b0;
            dev_data = 1'(i % 2);
            repeat (HALF) begin
                @(negedge clk);
                if (ps2_clk_oe || ps2_data_oe || busy) drove = 1'b1;
            end
            dev_clk = 1'b1;
            repeat (HALF) begin
                @(negedge clk);
                if (ps2_clk_oe || ps2_data_oe || busy) drove = 1'b1;
            end
        end
        dev_data = 1'b1;
        total++;
        if (drove) begin
            bad++;
            $display("FAIL idle_ignore: host drove lines or went busy got 1 want 0");
        end
    endtask

    task automatic test_send_bytes();
        logic [7:0]  list[8];
        logic [10:0] bits;
        int          inh_len, d0, e0;
        bit          ok, ok2;
        list[0] = 8'hED;
        list[1] = 8'h00;
        list[2] = 8'h01;
        list[3] = 8'hFF;
        for (int i = 4; i < 8; i++) list[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            start_send(list[i], 1'b0, ok);
            device_xfer(1'b1, 0, bits, inh_len, ok2);
            total++;
            if (!(ok && ok2)) begin
                bad++;
                $display("FAIL send_start_%0d: handshake/device got timeout want progress", i);
            end
            wait_ready(ok);
            total++;
            if (bits !== exp_frame(list[i])) begin
                bad++;
                $display("FAIL send_frame %h: got %b want %b", list[i], bits, exp_frame(list[i]));
            end
            total++;
            if (inh_len != INH) begin
                bad++;
                $display("FAIL send_inhibit %h: got %0d want %0d", list[i], inh_len, INH);
            end
            total++;
            if (done_cnt - d0 != 1 || err_cnt != e0 || !ok) begin
                bad++;
                $display("FAIL send_done %h: done got %0d want 1, err got %0d want 0, ready %0d",
                         list[i], done_cnt - d0, err_cnt - e0, ok);
            end
        end
    endtask

    task automatic test_no_ack();
        logic [10:0] bits;
        int          inh_len, d0, e0, a0;
        bit          ok, ok2;
        logic [7:0]  b;
        b  = 8'($urandom);
        d0 = done_cnt;
        e0 = err_cnt;
        a0 = attempt_cnt;
        start_send(b, 1'b0, ok);
        for (int i = 0; i < ATTEMPTS; i++) device_xfer(1'b0, 0, bits, inh_len, ok2);
        wait_ready(ok);
        total++;
        if (err_cnt - e0 != 1 || done_cnt != d0) begin
            bad++;
            $display("FAIL no_ack_pulses: err got %0d want 1, done got %0d want 0",
                     err_cnt - e0, done_cnt - d0);
        end
        total++;
        if (attempt_cnt - a0 != ATTEMPTS) begin
            bad++;
            $display("FAIL no_ack_attempts: got %0d want %0d", attempt_cnt - a0, ATTEMPTS);
        end
        total++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00 || bits[8:1] !== b) begin
            bad++;
            $display("FAIL no_ack_lines: oe got %b want 00, byte got %h want %h",
                     {ps2_clk_oe, ps2_data_oe}, bits[8:1], b);
        end
    endtask

    task automatic test_timeout();
        int  n, cnt, d0, e0, a0, exp_cnt, limit;
        bit  ok;
        d0 = done_cnt;
        e0 = err_cnt;
        a0 = attempt_cnt;
        exp_cnt = (ATTEMPTS - 1) * (TMO + 1 + 2 * INH) + TMO + 1;
        limit   = exp_cnt + 500;
        start_send(8'($urandom), 1'b0, ok);
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        cnt = 0;
        while (tx_err !== 1'b1 && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
        total++;
        if (cnt < exp_cnt - 1 || cnt > exp_cnt + 4) begin
            bad++;
            $display("FAIL timeout_latency: got %0d cycles want %0d", cnt, exp_cnt);
        end
        wait_ready(ok);
        total++;
        if (err_cnt - e0 != 1 || done_cnt != d0 || attempt_cnt - a0 != ATTEMPTS) begin
            bad++;
            $display("FAIL timeout_result: err %0d want 1, done %0d want 0, attempts %0d want %0d",
                     err_cnt - e0, done_cnt - d0, attempt_cnt - a0, ATTEMPTS);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] bits;
        int          inh_len, d0, e0;
        bit          ok, ok2;
        logic [7:0]  b;
        b = 8'($urandom) & 8'hEF;
        start_send(b, 1'b0, ok);
        device_xfer(1'b1, 5, bits, inh_len, ok2);
        total++;
        if (ps2_data_oe !== ~b[4]) begin
            bad++;
            $display("FAIL mid_bit4: data_oe got %b want %b", ps2_data_oe, ~b[4]);
        end
        d0 = done_cnt;
        e0 = err_cnt;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset_oe: clk_oe/data_oe/busy got %b want 000",
                     {ps2_clk_oe, ps2_data_oe, busy});
        end
        dev_clk = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (done_cnt != d0 || err_cnt != e0) begin
            bad++;
            $display("FAIL mid_reset_pulse: done got %0d err got %0d want 0 0",
                     done_cnt - d0, err_cnt - e0);
        end
        d0 = done_cnt;
        start_send(8'hF4, 1'b0, ok);
        device_xfer(1'b1, 0, bits, inh_len, ok2);
        wait_ready(ok);
        total++;
        if (bits !== exp_frame(8'hF4) || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL mid_reset_resend: frame got %b want %b, done got %0d want 1",
                     bits, exp_frame(8'hF4), done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits1, bits2;
        int          inh1, inh2, d0, n;
        bit          ok, ok1, ok2;
        logic [7:0]  a, b;
        a  = 8'($urandom);
        b  = ~a;
        d0 = done_cnt;
        start_send(a, 1'b1, ok);
        fork
            device_xfer(1'b1, 0, bits1, inh1, ok1);
            begin
                for (int i = 0; i < 20000; i++) begin
                    @(negedge clk);
                    if (tx_done === 1'b1) begin
                        tx_data = b;
                        break;
                    end
                    tx_data = 8'($urandom);
                end
            end
        join
        n = 0;
        while (tx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (tx_ready !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        device_xfer(1'b1, 0, bits2, inh2, ok2);
        wait_ready(ok);
        total++;
        if (bits1 !== exp_frame(a) || inh1 != INH) begin
            bad++;
            $display("FAIL hold_first: frame got %b want %b, inhibit got %0d want %0d",
                     bits1, exp_frame(a), inh1, INH);
        end
        total++;
        if (bits2 !== exp_frame(b) || inh2 != INH) begin
            bad++;
            $display("FAIL hold_second: frame got %b want %b, inhibit got %0d want %0d",
                     bits2, exp_frame(b), inh2, INH);
        end
        total++;
        if (done_cnt - d0 != 2) begin
            bad++;
            $display("FAIL hold_done: got %0d want 2", done_cnt - d0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_idle_ignore();
        test_send_bytes();
        test_no_ack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, bench did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It is the outbound counterpart of the keyboard receive path on the PS2_I port of the IO arbiter. It accepts one command byte from the memory/IO side (IO_OUT direction) and serialises it to the keyboard using the PS/2 request-to-send protocol. Typical bytes are 8'hED (set LEDs), 8'hFF (reset) and 8'hF4 (enable). It drives open-drain enables for ps2_clk and ps2_data; the pad tristates live outside the block.

Parameters:
INHIBIT_CYCLES, 5000, cycles to hold ps2_clk low before the start bit (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum cycles to wait for any single device clock edge (15 ms at 50 MHz).
SYNC_STAGES, 2, flop depth of the input synchronisers on ps2_clk_i and ps2_data_i (minimum 2).
RETRY_MAX, 2, automatic resend attempts; used only when PS2_TX_RETRY_EN is defined.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tx_data  in  8  command byte
tx_valid  in  1  request to send tx_data
tx_ready  out  1  block can accept a byte
tx_done  out  1  one-cycle pulse: byte acknowledged by the device
tx_err  out  1  one-cycle pulse: timeout or missing ACK
busy  out  1  transfer in progress
ps2_clk_i  in  1  raw PS/2 clock line
ps2_data_i  in  1  raw PS/2 data line
ps2_clk_oe  out  1  1 = pull the clock line low
ps2_data_oe  out  1  1 = pull the data line low

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - tx_ready=1; tx_done, tx_err, busy, ps2_clk_oe and ps2_data_oe are all 0.
  - The shift register and counters are cleared.
- Handshake:
  - A byte is accepted on the cycle where tx_valid && tx_ready.
  - tx_data is latched together with odd parity (~^tx_data).
  - tx_ready falls on the next cycle and stays low until the cycle after tx_done or tx_err.
  - tx_valid while tx_ready=0 is ignored.
- Synchroniser and edge detect:
  - ps2_clk_i and ps2_data_i each pass through SYNC_STAGES flops.
  - A falling edge is detected when the previous synchronised clock is 1 and the current one is 0.
- States:
  - IDLE: ps2_clk_oe=0, ps2_data_oe=0. On accept, go to INHIBIT.
  - INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES cycles. In the final cycle also assert ps2_data_oe=1 (start bit), then go to RELEASE.
  - RELEASE: ps2_clk_oe=0, ps2_data_oe stays 1. Wait for the first falling edge, then go to DATA.
  - DATA:
    - On each falling edge, drive bit n (LSB first); ps2_data_oe = ~bit.
    - The 4-bit counter runs 0..7; after bit 7 go to PARITY.
  - PARITY: on the next falling edge, drive the parity bit, then go to STOP.
  - STOP: on the next falling edge, set ps2_data_oe=0 (release), then go to ACK.
  - ACK: on the next falling edge, sample synchronised data.
    - 0: go to WAIT_IDLE.
    - 1: go to ERR.
  - WAIT_IDLE: wait until synchronised clock=1 and data=1, then go to DONE.
  - DONE: pulse tx_done for one cycle, then go to IDLE.
  - ERR: release both lines, pulse tx_err for one cycle, then go to IDLE.
- busy=1 in every state except IDLE.
- Timeout:
  - The counter reloads on every falling edge and on entry to RELEASE.
  - Any state from RELEASE to WAIT_IDLE that reaches TIMEOUT_CYCLES goes to ERR.
- Reset mid-transfer: both oe outputs go to 0 immediately (asynchronous). No done/err pulse is produced.
- Device-initiated traffic during IDLE is ignored (that is the receiver's job). The block never drives the lines in IDLE.
- The 20-bit timeout counter saturates; it never wraps.

Optional Feature:
PS2_TX_RETRY_EN.
- Defined:
  - A missing ACK or a timeout goes to RETRY instead of ERR.
  - RETRY releases both lines for INHIBIT_CYCLES cycles, then re-enters INHIBIT with the same latched byte.
  - After RETRY_MAX failed retries, go to ERR.
  - The retry counter clears on accept.
- Undefined: the first failure goes straight to ERR. The RETRY state, the retry counter and RETRY_MAX are absent.

Decomposition:
- Add to package gc:
  - typedef enum ps2_tx_state_t {IDLE, INHIBIT, RELEASE, DATA, PARITY, STOP, ACK, WAIT_IDLE, DONE, ERR, RETRY}.
  - PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_FRAME_BITS=11.
- Sub-module ps2_line_sync:
  - Parameter SYNC_STAGES.
  - Inputs: clk, rst, raw line.
  - Outputs: synchronised level and fall pulse.
  - Instantiated once for the clock line and once for the data line. This sub-module is shared with the receiver.

Test Plan:
- Send 8'hED with a device model that ACKs:
  - ps2_clk_oe is held for 5000 cycles.
  - Data bits 1,0,1,1,0,1,1,1 are observed LSB first, then parity 1, then stop (released).
  - tx_done pulses once and tx_ready returns to 1.
- Send 8'h00: parity bit is 1. Send 8'h01: parity bit is 0. Both produce tx_done.
- Device model withholds ACK (data high on the 11th edge), macro undefined: tx_err pulses once, tx_done is never asserted, both oe=0.
- Device never clocks after release: tx_err fires at 750000 cycles after entering RELEASE.
- Same case with PS2_TX_RETRY_EN defined: exactly 3 attempts (1 + RETRY_MAX), then tx_err.
- Assert rst during DATA bit 4: oe outputs drop in the same cycle, and the following tx_valid with 8'hF4 completes normally.
- Hold tx_valid high with a changing tx_data during a transfer: only the byte accepted at the handshake is transmitted.
